// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM cell sequencer.
package lstm_pkg;
    typedef enum logic [1:0] {GATE_I = 2'd0, GATE_F = 2'd1, GATE_G = 2'd2, GATE_O = 2'd3} gate_e;
    typedef enum logic [1:0] {SEL_WX = 2'd0, SEL_WH = 2'd1, SEL_BX = 2'd2, SEL_BH = 2'd3} cfg_sel_e;

    localparam int unsigned LSTM_DLY   = 7;
    localparam int unsigned WDOG_LIMIT = 15;
    localparam int unsigned Q8_SCALE   = 256;
endpackage

// File: rtl/lstm_fifo.sv
// Synchronous first-word-fall-through FIFO; simultaneous push and pop both take effect.
module lstm_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/lstm_sequencer.sv
// Feeds queued samples one at a time to an external LSTM cell, collects results,
// distributes gate weights/biases, and guards each cell request with a watchdog.
module lstm_sequencer
    import lstm_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SEQ_DEPTH = 16,
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cfg_sel,
    input  logic [1:0]            cfg_gate,
    input  logic [WIDTH-1:0]      cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      h_init,
    input  logic [WIDTH-1:0]      C_init,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [WIDTH-1:0]      m_y,
    output logic [WIDTH-1:0]      m_c,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  err,
    output logic [3:0][WIDTH-1:0] weight_x,
    output logic [3:0][WIDTH-1:0] weight_h,
    output logic [3:0][WIDTH-1:0] bias_x,
    output logic [3:0][WIDTH-1:0] bias_h,
    output logic [3:0]            weight_x_valid,
    output logic [3:0]            weight_h_valid,
    output logic [3:0]            bias_x_valid,
    output logic [3:0]            bias_h_valid,
    input  logic                  cell_ready,
    output logic [WIDTH-1:0]      cell_x,
    output logic                  cell_x_valid,
    output logic [WIDTH-1:0]      cell_h,
    output logic                  cell_h_valid,
    output logic [WIDTH-1:0]      cell_C,
    output logic                  cell_C_valid,
    input  logic [WIDTH-1:0]      cell_y,
    input  logic [WIDTH-1:0]      cell_C_out,
    input  logic                  cell_valid
);
    localparam int unsigned IW = WIDTH + 1;
    localparam int unsigned RW = 2 * WIDTH + 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam logic [3:0] WDOG_LAST = 4'(WDOG_LIMIT - 1);

    logic [0:0]            r_state;
    logic                  r_first;
    logic                  r_cur_last;
    logic                  r_err;
    logic [3:0]            r_wdog;
    logic [WIDTH-1:0]      r_cell_x, r_cell_h, r_cell_C;
    logic                  r_cell_x_v, r_cell_h_v, r_cell_C_v;
    logic [3:0][WIDTH-1:0] r_wx, r_wh, r_bx, r_bh;
    logic [3:0]            r_wx_v, r_wh_v, r_bx_v, r_bh_v;

    logic                  w_cfg_acc;
    logic                  w_issue;
    logic                  w_done;
    logic                  w_in_empty, w_in_full;
    logic                  w_res_empty, w_res_full;
    logic [IW-1:0]         w_in_head;
    logic [RW-1:0]         w_res_head;
    logic [3:0]            w_gate_oh;

    assign cfg_ready = (r_state == ST_IDLE) && cell_ready;
    assign w_cfg_acc = cfg_valid && cfg_ready;
    assign w_gate_oh = 4'b0001 << cfg_gate;
    // A config write owns the cycle; issue waits so the cell never sees both at once.
    assign w_issue   = (r_state == ST_IDLE) && !w_in_empty && !w_res_full && cell_ready && !w_cfg_acc;
    assign w_done    = (r_state == ST_WAIT) && cell_valid;

    lstm_fifo #(.W(IW), .DEPTH(SEQ_DEPTH)) u_in_fifo (
        .clk(clk), .rst(rst), .i_push(s_valid), .i_data({s_data, s_last}), .i_pop(w_issue),
        .o_data(w_in_head), .o_empty(w_in_empty), .o_full(w_in_full)
    );

    lstm_fifo #(.W(RW), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk(clk), .rst(rst), .i_push(w_done), .i_data({cell_y, cell_C_out, r_cur_last}),
        .i_pop(m_ready), .o_data(w_res_head), .o_empty(w_res_empty), .o_full(w_res_full)
    );

    assign s_ready               = !w_in_full;
    assign m_valid               = !w_res_empty;
    assign {m_y, m_c, m_last}    = w_res_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_first    <= 1'b1;
            r_cur_last <= 1'b0;
            r_err      <= 1'b0;
            r_wdog     <= '0;
            r_cell_x   <= '0;
            r_cell_h   <= '0;
            r_cell_C   <= '0;
            r_cell_x_v <= 1'b0;
            r_cell_h_v <= 1'b0;
            r_cell_C_v <= 1'b0;
        end else begin
            r_cell_x_v <= 1'b0;
            r_cell_h_v <= 1'b0;
            r_cell_C_v <= 1'b0;
            if (w_issue) begin
                r_state    <= ST_WAIT;
                r_wdog     <= '0;
                r_cell_x   <= w_in_head[IW-1:1];
                r_cell_x_v <= 1'b1;
                r_cur_last <= w_in_head[0];
                r_first    <= w_in_head[0];
                if (r_first) begin
                    r_cell_h   <= h_init;
                    r_cell_C   <= C_init;
                    r_cell_h_v <= 1'b1;
                    r_cell_C_v <= 1'b1;
                end
            end else if (r_state == ST_WAIT) begin
                if (cell_valid) begin
                    r_state <= ST_IDLE;
                end else if (r_wdog == WDOG_LAST) begin
                    r_state <= ST_IDLE;
                    r_err   <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wx   <= '0;
            r_wh   <= '0;
            r_bx   <= '0;
            r_bh   <= '0;
            r_wx_v <= '0;
            r_wh_v <= '0;
            r_bx_v <= '0;
            r_bh_v <= '0;
        end else begin
            r_wx_v <= '0;
            r_wh_v <= '0;
            r_bx_v <= '0;
            r_bh_v <= '0;
            if (w_cfg_acc) begin
                case (cfg_sel_e'(cfg_sel))
                    SEL_WX: begin r_wx[cfg_gate] <= cfg_data; r_wx_v <= w_gate_oh; end
                    SEL_WH: begin r_wh[cfg_gate] <= cfg_data; r_wh_v <= w_gate_oh; end
                    SEL_BX: begin r_bx[cfg_gate] <= cfg_data; r_bx_v <= w_gate_oh; end
                    SEL_BH: begin r_bh[cfg_gate] <= cfg_data; r_bh_v <= w_gate_oh; end
                endcase
            end
        end
    end

    assign err            = r_err;
    assign cell_x         = r_cell_x;
    assign cell_x_valid   = r_cell_x_v;
    assign cell_h         = r_cell_h;
    assign cell_h_valid   = r_cell_h_v;
    assign cell_C         = r_cell_C;
    assign cell_C_valid   = r_cell_C_v;
    assign weight_x       = r_wx;
    assign weight_h       = r_wh;
    assign bias_x         = r_bx;
    assign bias_h         = r_bh;
    assign weight_x_valid = r_wx_v;
    assign weight_h_valid = r_wh_v;
    assign bias_x_valid   = r_bx_v;
    assign bias_h_valid   = r_bh_v;
endmodule

// File: tb/tb_lstm_sequencer.sv
// Self-checking bench for lstm_sequencer with a fixed-latency cell model and a queue-based reference.
`timescale 1ns/1ps
module tb_lstm_sequencer;
    import lstm_pkg::*;

    localparam int W  = 16;
    localparam int SD = 16;
    localparam int RD = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          cfg_sel = '0, cfg_gate = '0;
    logic [W-1:0]        cfg_data = '0;
    logic                cfg_valid = 1'b0, cfg_ready;
    logic [W-1:0]        h_init = '0, C_init = '0;
    logic [W-1:0]        s_data = '0;
    logic                s_last = 1'b0, s_valid = 1'b0, s_ready;
    logic [W-1:0]        m_y, m_c;
    logic                m_last, m_valid, m_ready = 1'b1;
    logic                err;
    logic [3:0][W-1:0]   weight_x, weight_h, bias_x, bias_h;
    logic [3:0]          weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid;
    logic                cell_ready = 1'b1;
    logic [W-1:0]        cell_x, cell_h, cell_C;
    logic                cell_x_valid, cell_h_valid, cell_C_valid;
    logic [W-1:0]        cell_y = '0, cell_C_out = '0;
    logic                cell_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    lstm_sequencer #(.WIDTH(W), .SEQ_DEPTH(SD), .RES_DEPTH(RD)) dut (
        .clk(clk), .rst(rst),
        .cfg_sel(cfg_sel), .cfg_gate(cfg_gate), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .h_init(h_init), .C_init(C_init),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .m_y(m_y), .m_c(m_c), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .err(err),
        .weight_x(weight_x), .weight_h(weight_h), .bias_x(bias_x), .bias_h(bias_h),
        .weight_x_valid(weight_x_valid), .weight_h_valid(weight_h_valid),
        .bias_x_valid(bias_x_valid), .bias_h_valid(bias_h_valid),
        .cell_ready(cell_ready),
        .cell_x(cell_x), .cell_x_valid(cell_x_valid), .cell_h(cell_h), .cell_h_valid(cell_h_valid),
        .cell_C(cell_C), .cell_C_valid(cell_C_valid),
        .cell_y(cell_y), .cell_C_out(cell_C_out), .cell_valid(cell_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Cell model: answers LSTM_DLY cycles after each cell_x_valid; ignores rst on purpose.
    int          cell_cnt = 0;
    logic [W-1:0] cell_pend = '0;
    bit          cell_mute = 1'b0;
    always @(negedge clk) begin
        cell_valid = 1'b0;
        if (cell_cnt > 0) begin
            cell_cnt--;
            if (cell_cnt == 0 && !cell_mute) begin
                cell_valid = 1'b1;
                cell_y     = cell_pend + 16'h0011;
                cell_C_out = cell_pend ^ 16'h00FF;
            end
        end
        if (cell_x_valid) begin
            cell_pend = cell_x;
            cell_cnt  = LSTM_DLY;
        end
    end

    logic [W-1:0] iss_x[$], iss_h[$], iss_C[$];
    bit           iss_hv[$], iss_cv[$];
    int unsigned  iss_cyc[$];
    logic [W-1:0] rx_y[$], rx_c[$];
    bit           rx_last[$];
    int unsigned  rx_cyc[$];
    int unsigned  mv_seen = 0;
    int unsigned  orphan_hc = 0;
    always @(negedge clk) begin
        if (cell_x_valid) begin
            iss_x.push_back(cell_x);   iss_h.push_back(cell_h);   iss_C.push_back(cell_C);
            iss_hv.push_back(cell_h_valid); iss_cv.push_back(cell_C_valid); iss_cyc.push_back(cyc);
        end else if (cell_h_valid || cell_C_valid) begin
            orphan_hc++;
        end
        if (m_valid) mv_seen++;
        if (m_valid && m_ready) begin
            rx_y.push_back(m_y); rx_c.push_back(m_c); rx_last.push_back(m_last); rx_cyc.push_back(cyc);
        end
    end

    logic [W-1:0] ex_x[$];
    bit           ex_l[$];
    bit           tb_first = 1'b1;
    logic [W-1:0] exp_w [4][4];

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        iss_x.delete(); iss_h.delete(); iss_C.delete(); iss_hv.delete(); iss_cv.delete(); iss_cyc.delete();
        rx_y.delete(); rx_c.delete(); rx_last.delete(); rx_cyc.delete();
        mv_seen = 0; orphan_hc = 0; ex_x.delete(); ex_l.delete();
    endtask

    task automatic do_reset(input int n);
        sync();
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        tb_first = 1'b1;
        for (int s = 0; s < 4; s++) for (int g = 0; g < 4; g++) exp_w[s][g] = '0;
    endtask

    task automatic push_sample(input logic [W-1:0] d, input bit l, output bit ok);
        bit acc;
        ok = 1'b0;
        sync();
        s_data = d; s_last = l; s_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); acc = s_ready;
            @(posedge clk); #1;
            if (acc) begin ok = 1'b1; break; end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (rx_y.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    function automatic logic [W-1:0] dut_word(input int s, input int g);
        case (s)
            0: return weight_x[g];
            1: return weight_h[g];
            2: return bias_x[g];
            default: return bias_h[g];
        endcase
    endfunction

    task automatic test_reset();
        do_reset(3);
        @(negedge clk);
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        n_checks++; if ({cell_x_valid, cell_h_valid, cell_C_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_cell_valids got=%b exp=000", {cell_x_valid, cell_h_valid, cell_C_valid}); end
        n_checks++; if ({weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid} !== 16'h0) begin
            n_fail++; $display("FAIL reset_strobes got=%h exp=0000", {weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid}); end
    endtask

    task automatic test_cfg();
        int s, g;
        logic [W-1:0] d;
        logic [15:0] strobes, exp_strobes;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin s = 0; g = int'(GATE_G); d = 16'(Q8_SCALE); end
            else begin s = $urandom_range(0, 3); g = $urandom_range(0, 3); d = W'($urandom); end
            sync();
            n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_ready_idle got=%b exp=1", cfg_ready); end
            cfg_sel = 2'(s); cfg_gate = 2'(g); cfg_data = d; cfg_valid = 1'b1;
            @(posedge clk); #1 cfg_valid = 1'b0;
            exp_w[s][g] = d;
            exp_strobes = 16'h1 << ((3 - s) * 4 + g);
            @(negedge clk);
            strobes = {weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid};
            n_checks++; if (dut_word(s, g) !== d) begin n_fail++; $display("FAIL cfg_word[%0d][%0d] got=%h exp=%h", s, g, dut_word(s, g), d); end
            n_checks++; if (strobes !== exp_strobes) begin n_fail++; $display("FAIL cfg_strobe_on got=%h exp=%h", strobes, exp_strobes); end
            @(negedge clk);
            strobes = {weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid};
            n_checks++; if (strobes !== 16'h0) begin n_fail++; $display("FAIL cfg_strobe_off got=%h exp=0000", strobes); end
        end
        for (int si = 0; si < 4; si++) for (int gi = 0; gi < 4; gi++) begin
            n_checks++; if (dut_word(si, gi) !== exp_w[si][gi]) begin
                n_fail++; $display("FAIL cfg_hold[%0d][%0d] got=%h exp=%h", si, gi, dut_word(si, gi), exp_w[si][gi]); end
        end
    endtask

    task automatic test_sequence();
        bit ok, f;
        h_init = 16'd5; C_init = 16'hFFFD;
        clear_logs();
        for (int i = 0; i < 3; i++) begin ex_x.push_back(W'($urandom)); ex_l.push_back(i == 2); end
        for (int i = 0; i < 3; i++) begin
            push_sample(ex_x[i], ex_l[i], ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL seq_push_timeout idx=%0d got=0 exp=1", i); end
        end
        wait_rx(3, 80, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL seq_rx_timeout got=%0d exp=3", rx_y.size()); end
        n_checks++; if (iss_x.size() != 3) begin n_fail++; $display("FAIL seq_issue_count got=%0d exp=3", iss_x.size()); end
        n_checks++; if (orphan_hc != 0) begin n_fail++; $display("FAIL seq_orphan_hc got=%0d exp=0", orphan_hc); end
        f = tb_first;
        for (int i = 0; i < 3 && i < iss_x.size(); i++) begin
            n_checks++; if (iss_x[i] !== ex_x[i]) begin n_fail++; $display("FAIL seq_x[%0d] got=%h exp=%h", i, iss_x[i], ex_x[i]); end
            n_checks++; if ({iss_hv[i], iss_cv[i]} !== {f, f}) begin n_fail++; $display("FAIL seq_hc_valid[%0d] got=%b%b exp=%b%b", i, iss_hv[i], iss_cv[i], f, f); end
            if (f) begin
                n_checks++; if ({iss_h[i], iss_C[i]} !== {16'd5, 16'hFFFD}) begin
                    n_fail++; $display("FAIL seq_hc_init got=%h/%h exp=0005/fffd", iss_h[i], iss_C[i]); end
            end
            if (i > 0) begin
                n_checks++; if (iss_cyc[i] - iss_cyc[i-1] != 9) begin
                    n_fail++; $display("FAIL seq_spacing[%0d] got=%0d exp=9", i, iss_cyc[i] - iss_cyc[i-1]); end
            end
            f = ex_l[i];
        end
        tb_first = f;
        for (int i = 0; i < 3 && i < rx_y.size(); i++) begin
            n_checks++; if ({rx_y[i], rx_c[i], rx_last[i]} !== {ex_x[i] + 16'h0011, ex_x[i] ^ 16'h00FF, ex_l[i]}) begin
                n_fail++; $display("FAIL seq_result[%0d] got=%h/%h/%b exp=%h/%h/%b", i, rx_y[i], rx_c[i], rx_last[i],
                                   ex_x[i] + 16'h0011, ex_x[i] ^ 16'h00FF, ex_l[i]); end
        end
        if (rx_cyc.size() > 0 && iss_cyc.size() > 0) begin
            n_checks++; if (rx_cyc[0] - iss_cyc[0] != 8) begin
                n_fail++; $display("FAIL seq_latency got=%0d exp=8", rx_cyc[0] - iss_cyc[0]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok, f;
        clear_logs();
        sync(); m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin ex_x.push_back(W'($urandom)); ex_l.push_back(i == 5 ? 1'b1 : 1'($urandom_range(0, 1))); end
        for (int i = 0; i < 6; i++) begin
            push_sample(ex_x[i], ex_l[i], ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_push_timeout idx=%0d got=0 exp=1", i); end
        end
        repeat (60) @(negedge clk);
        n_checks++; if (iss_x.size() != 4) begin n_fail++; $display("FAIL bp_stall_issues got=%0d exp=4", iss_x.size()); end
        n_checks++; if (rx_y.size() != 0) begin n_fail++; $display("FAIL bp_no_pop got=%0d exp=0", rx_y.size()); end
        n_checks++; if ({m_valid, m_y} !== {1'b1, ex_x[0] + 16'h0011}) begin
            n_fail++; $display("FAIL bp_head got=%b/%h exp=1/%h", m_valid, m_y, ex_x[0] + 16'h0011); end
        sync(); m_ready = 1'b1;
        wait_rx(6, 120, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_rx_timeout got=%0d exp=6", rx_y.size()); end
        n_checks++; if (iss_x.size() != 6) begin n_fail++; $display("FAIL bp_issue_count got=%0d exp=6", iss_x.size()); end
        f = tb_first;
        for (int i = 0; i < 6 && i < iss_x.size(); i++) begin
            n_checks++; if ({iss_x[i], iss_hv[i]} !== {ex_x[i], f}) begin
                n_fail++; $display("FAIL bp_issue[%0d] got=%h/%b exp=%h/%b", i, iss_x[i], iss_hv[i], ex_x[i], f); end
            f = ex_l[i];
        end
        tb_first = f;
        for (int i = 0; i < 6 && i < rx_y.size(); i++) begin
            n_checks++; if ({rx_y[i], rx_c[i], rx_last[i]} !== {ex_x[i] + 16'h0011, ex_x[i] ^ 16'h00FF, ex_l[i]}) begin
                n_fail++; $display("FAIL bp_result[%0d] got=%h/%h/%b exp=%h/%h/%b", i, rx_y[i], rx_c[i], rx_last[i],
                                   ex_x[i] + 16'h0011, ex_x[i] ^ 16'h00FF, ex_l[i]); end
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        int unsigned err_cyc;
        clear_logs();
        cell_mute = 1'b1;
        push_sample(W'($urandom), 1'b1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wd_push_timeout got=0 exp=1"); end
        ok = 1'b0; err_cyc = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (err) begin ok = 1'b1; err_cyc = cyc; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wd_err_timeout got=0 exp=1"); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL wd_back_idle got=%b exp=1", cfg_ready); end
        if (ok && iss_cyc.size() > 0) begin
            n_checks++; if (err_cyc - iss_cyc[0] != WDOG_LIMIT) begin
                n_fail++; $display("FAIL wd_delay got=%0d exp=%0d", err_cyc - iss_cyc[0], WDOG_LIMIT); end
        end
        repeat (20) @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got=%b exp=1", err); end
        n_checks++; if (mv_seen != 0) begin n_fail++; $display("FAIL wd_no_result got=%0d exp=0", mv_seen); end
        n_checks++; if (iss_x.size() != 1) begin n_fail++; $display("FAIL wd_issue_count got=%0d exp=1", iss_x.size()); end
        do_reset(1);
        cell_mute = 1'b0;
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wd_cleared got=%b exp=0", err); end
    endtask

    task automatic test_fill_rst();
        bit ok;
        sync(); cell_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < SD; i++) begin
            push_sample(W'($urandom), 1'($urandom_range(0, 1)), ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_push_timeout idx=%0d got=0 exp=1", i); end
        end
        @(negedge clk);
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_s_ready got=%b exp=0", s_ready); end
        n_checks++; if (iss_x.size() != 0) begin n_fail++; $display("FAIL fill_no_issue got=%0d exp=0", iss_x.size()); end
        sync(); cell_ready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (iss_x.size() > 0) begin ok = 1'b1; break; end end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_issue_timeout got=0 exp=1"); end
        repeat (2) @(negedge clk);
        do_reset(1);
        mv_seen = 0;
        @(negedge clk);
        n_checks++; if ({s_ready, m_valid, err, cfg_ready} !== 4'b1001) begin
            n_fail++; $display("FAIL rst_mid_flags got=%b exp=1001", {s_ready, m_valid, err, cfg_ready}); end
        n_checks++; if ({cell_x_valid, cell_h_valid, cell_C_valid, cell_x} !== {3'b000, 16'h0}) begin
            n_fail++; $display("FAIL rst_mid_cell got=%b%b%b/%h exp=000/0000", cell_x_valid, cell_h_valid, cell_C_valid, cell_x); end
        n_checks++; if ({weight_x, weight_h, bias_x, bias_h} !== '0) begin
            n_fail++; $display("FAIL rst_mid_words got=%h exp=0", {weight_x, weight_h, bias_x, bias_h}); end
        repeat (20) @(negedge clk);
        n_checks++; if (mv_seen != 0 || rx_y.size() != 0) begin
            n_fail++; $display("FAIL rst_late_cell got=%0d exp=0", mv_seen); end
        n_checks++; if (iss_x.size() != 1) begin n_fail++; $display("FAIL rst_issue_count got=%0d exp=1", iss_x.size()); end
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_sequence();
        test_back_to_back();
        test_watchdog();
        test_fill_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/lstm_sequencer.md
LSTM_SEQUENCER -- requirements
Module: lstm_sequencer

Interface
REQ-001 Parameters: WIDTH, default 16, signed Q8 word width; SEQ_DEPTH, default 16, input FIFO entries; RES_DEPTH, default 4, result FIFO entries.
REQ-002 Ports: clk  in  1  single clock; all logic on posedge.
REQ-003 Ports: rst  in  1  reset, synchronous, active-high.
REQ-004 Ports: cfg_sel  in  2  target: 0 weight_x, 1 weight_h, 2 bias_x, 3 bias_h.
REQ-005 Ports: cfg_gate  in  2  gate index: 0 i, 1 f, 2 g, 3 o.
REQ-006 Ports: cfg_data, cfg_valid, cfg_ready  in/in/out  WIDTH/1/1  config write handshake.
REQ-007 Ports: h_init, C_init  in  WIDTH each  initial state for each new sequence.
REQ-008 Ports: s_data, s_last, s_valid, s_ready  in/in/in/out  WIDTH/1/1/1  sample stream; s_last marks the final sample of a sequence.
REQ-009 Ports: m_y, m_c, m_last, m_valid, m_ready  out/out/out/out/in  WIDTH/WIDTH/1/1/1  result stream.
REQ-010 Ports: err  out  1  sticky watchdog error.
REQ-011 Ports: weight_x, weight_h, bias_x, bias_h  out  4xWIDTH each  config words to cell, indexed by gate.
REQ-012 Ports: weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid  out  4 each  one-hot per-gate write strobes.
REQ-013 Ports: cell_ready  in  1  cell accepts inputs this cycle.
REQ-014 Ports: cell_x/cell_x_valid, cell_h/cell_h_valid, cell_C/cell_C_valid  out  WIDTH/1 each  cell inputs.
REQ-015 Ports: cell_y, cell_C_out, cell_valid  in  WIDTH/WIDTH/1  cell results.

Function
REQ-016 All cell-side outputs shall be registered; every *_valid to the cell shall be a single-cycle pulse.
REQ-017 cfg_ready shall be (state==IDLE && cell_ready); an accepted write shall drive the selected word and its one-hot strobe in the next cycle only; word registers hold their value.
REQ-018 FSM states: IDLE, WAIT. IDLE->WAIT when input FIFO non-empty, result FIFO count < RES_DEPTH, cell_ready high and no cfg write accepted that cycle; the FIFO head is popped on that edge.
REQ-019 The cycle after the pop, cell_x_valid=1 with cell_x=popped sample; if flag first=1, cell_h_valid=cell_C_valid=1 with h_init/C_init in that same cycle.
REQ-020 first shall be set by reset and by popping a sample with last=1, and cleared by popping a sample with last=0.
REQ-021 WAIT->IDLE on cell_valid; {cell_y, cell_C_out, last of the issued sample} is written to the result FIFO on that edge; m_valid rises the next cycle (8 cycles after the cell_x_valid cycle).
REQ-022 Minimum issue period: 9 cycles from one cell_x_valid to the next.
REQ-023 Watchdog: a WAIT cycle counter; if 15 cycles elapse without cell_valid, set err (sticky until rst) and return to IDLE with no result written.
REQ-024 cell_valid in IDLE shall be ignored.
REQ-025 Input FIFO: s_ready=!full; a push and a pop in the same cycle shall both take effect; a sample pushed into an empty FIFO is poppable the next cycle.
REQ-026 Result FIFO: standard valid/ready; m_* are held stable while m_valid && !m_ready; a push and a pop in the same cycle shall both take effect.
REQ-027 Backpressure: result FIFO full blocks issue; no result shall ever be dropped.

Reset
REQ-028 On rst: both FIFOs empty, state IDLE, first=1, err=0, watchdog=0, all cell/config strobes=0, m_valid=0, s_ready=1, word registers=0.
REQ-029 rst asserted mid-WAIT shall abandon the in-flight sample; a later cell_valid is ignored.

Structure
REQ-030 Package lstm_pkg holds: gate enum {i,f,g,o}, cfg_sel enum, LSTM_DLY=7, WDOG_LIMIT=15, Q8 scale 256.
REQ-031 One sub-module, lstm_fifo (parameterised sync FIFO), instantiated twice.

Verification
REQ-032 Write cfg_sel=0, cfg_gate=2, data=0x0100 -> weight_x[2]=0x0100 and weight_x_valid=4'b0100 for exactly 1 cycle.
REQ-033 Push 3 samples (last on the third), h_init=5, C_init=-3 -> cell_h_valid/cell_C_valid only with the first x; 3 results, m_last on the third; cell_x_valid spacing = 9 cycles.
REQ-034 Hold m_ready=0 and push 6 samples -> exactly 4 issues, then stall; release m_ready -> remaining 2 issue; 6 results delivered in order.
REQ-035 Cell model that never asserts cell_valid -> err=1 after 15 WAIT cycles; FSM returns to IDLE; err stays set until rst.
REQ-036 Fill the input FIFO to SEQ_DEPTH -> s_ready=0; assert rst during WAIT -> all outputs at reset values the next cycle; a late cell_valid produces no m_valid.
